// File: rtl/fetch_if.sv
// Bus bundle of the fetch unit: instruction-memory port and the decode-side stream.
interface fetch_if;
  // Handshakes: a fetch transfers on a rising edge with imem_req_o && imem_gnt_i, and req/addr hold
  // until then; imem_rvalid_i returns one word per grant, in order, one or more cycles later;
  // decode takes an instruction when valid_o && !stall_i, and outputs hold while stalled.
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        stall_i;
  logic        valid_o;
  logic [31:0] instruction_o;
  logic [31:0] pc_o;

  modport master (
    output imem_req_o, imem_addr_o, valid_o, instruction_o, pc_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, stall_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, valid_o, instruction_o, pc_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, stall_i
  );
endinterface

// File: rtl/fetch.sv
// Instruction fetch: credit-limited sequential fetching into a small {pc, instruction} FIFO,
// with redirect flush and draining of responses that belong to the abandoned stream.
module fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic       clk_i,
  input  logic       n_rst,
  fetch_if.master    bus,
  output logic [1:0] state_o
);
  localparam int unsigned PW   = $clog2(BUF_DEPTH);
  localparam int unsigned CW   = $clog2(BUF_DEPTH + 1);
  localparam int unsigned CW1  = CW + 1;
  localparam int unsigned LAST = BUF_DEPTH - 1;
  localparam logic [CW:0]   DEPTH_W  = CW1'(BUF_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(LAST);
  localparam logic [31:0]   NOP      = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   buf_pc_q  [BUF_DEPTH];
  logic [31:0]   buf_ins_q [BUF_DEPTH];

  logic [CW:0]   inflight;
  logic [31:0]   target_pc;
  logic          req, grant, resp_ok, drop, valid, push, pop;
  logic          unused_rpc;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // A pop in the same cycle is deliberately not credited, so the request only looks at registers.
  assign inflight   = CW1'(count_q) + CW1'(outst_q);
  assign req        = n_rst && (state_q == RUN) && (inflight < DEPTH_W);
  assign grant      = req && bus.imem_gnt_i;
  assign resp_ok    = bus.imem_rvalid_i && (state_q == RUN) && (outst_q != '0);
  assign drop       = bus.imem_rvalid_i && (state_q == DRAIN) && (discard_q != '0);
  assign valid      = n_rst && (count_q != '0);
  assign push       = resp_ok && !bus.redirect_i;
  assign pop        = valid && !bus.stall_i && !bus.redirect_i;
  assign target_pc  = {bus.redirect_pc_i[31:2], 2'b00};
  assign unused_rpc = ^bus.redirect_pc_i[1:0];

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    outst_d    = outst_q;
    count_d    = count_q;
    discard_d  = discard_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    unique case (state_q)
      IDLE: begin
        state_d = RUN;
        if (bus.redirect_i) begin
          fetch_pc_d = target_pc;
          resp_pc_d  = target_pc;
        end
      end
      RUN: begin
        if (bus.redirect_i) begin
          // Everything granted so far (this cycle's grant included) is now stale.
          fetch_pc_d = target_pc;
          resp_pc_d  = target_pc;
          outst_d    = '0;
          count_d    = '0;
          rd_ptr_d   = '0;
          wr_ptr_d   = '0;
          discard_d  = outst_q + CW'(grant) - CW'(resp_ok);
          state_d    = (discard_d != '0) ? DRAIN : RUN;
        end else begin
          if (grant) fetch_pc_d = fetch_pc_q + 32'd4;
          outst_d = outst_q + CW'(grant) - CW'(resp_ok);
          if (push) begin
            wr_ptr_d  = ptr_inc(wr_ptr_q);
            resp_pc_d = resp_pc_q + 32'd4;
          end
          if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
          count_d = count_q + CW'(push) - CW'(pop);
        end
      end
      DRAIN: begin
        if (bus.redirect_i) begin
          fetch_pc_d = target_pc;
          resp_pc_d  = target_pc;
        end
        discard_d = discard_q - CW'(drop);
        if (discard_d == '0) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      count_q    <= '0;
      discard_q  <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      count_q    <= count_d;
      discard_q  <= discard_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      buf_pc_q[wr_ptr_q]  <= resp_pc_q;
      buf_ins_q[wr_ptr_q] <= bus.imem_rdata_i;
    end
  end

  assign bus.imem_req_o    = req;
  assign bus.imem_addr_o   = fetch_pc_q;
  assign bus.valid_o       = valid;
  assign bus.instruction_o = valid ? buf_ins_q[rd_ptr_q] : NOP;
  assign bus.pc_o          = valid ? buf_pc_q[rd_ptr_q] : 32'h0;
  assign state_o           = state_q;
endmodule
